// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared fetch constants, buffer entry type and PC alignment helper
package if_fetch_pkg;

    localparam int              XLEN         = 32;
    localparam int              INST_ALIGN   = 2;      // low PC bits that are always zero
    localparam logic [XLEN-1:0] INST_BYTES   = 32'd4;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] addr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:INST_ALIGN], {INST_ALIGN{1'b0}}};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - fetch stage bundle: imem request/response, redirect, pause, decode output
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_addr;
    logic            pause;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_addr;
    logic            inst_valid;

    modport master (
        output imem_req_valid, imem_req_addr, inst, inst_addr, inst_valid,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_en, redirect_addr, pause
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst, inst_addr, inst_valid,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_en, redirect_addr, pause
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - parameterised synchronous FIFO with clear and combinational head
module if_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    // next pointers, occupancy and storage; clear drops everything held
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: entries are only read while counted valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // an overflow means the upstream credit accounting is broken
    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !clear));

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, credit-limited imem requests, instruction buffer
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INST   = NOP_INST_DEF
) (
    input  logic      clk,
    input  logic      rst,
    if_fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d;   // requests handshaken but not yet answered
    logic [CW-1:0]   drop_q, drop_d;     // answers still owed to a pre-redirect PC stream
    logic [CW-1:0]   buf_count;
    logic            buf_empty;
    logic [CW:0]     credit_used;
    logic            req_valid;
    logic            hs;
    logic            resp_keep;
    logic            resp_drop;
    logic [XLEN-1:0] aq_head;
    logic            aq_empty;
    logic [CW-1:0]   aq_count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic [EW-1:0]   head_bits;

    // outstanding plus buffered may never exceed the buffer size, so every answer has a slot
    assign credit_used = {1'b0, outst_q} + {1'b0, buf_count};
    assign req_valid   = !rst && !bus.redirect_en && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign hs          = req_valid && bus.imem_req_ready;
    assign resp_drop   = bus.imem_resp_valid && (drop_q != '0);
    assign resp_keep   = bus.imem_resp_valid && (drop_q == '0);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;

    // next PC, outstanding and drop counts; a redirect turns every outstanding request stale
    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q + CW'(hs) - CW'(bus.imem_resp_valid);
        drop_d  = drop_q;
        if (bus.redirect_en) begin
            pc_d   = align_pc(bus.redirect_addr);
            drop_d = outst_q - CW'(bus.imem_resp_valid);
        end else begin
            if (hs) begin
                pc_d = pc_q + INST_BYTES;
            end
            if (resp_drop) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // fetch state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    if_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.redirect_en),
        .push      (hs),
        .push_data (pc_q),
        .pop       (resp_keep),
        .head      (aq_head),
        .empty     (aq_empty),
        .count     (aq_count)
    );

    assign push_entry = '{inst: bus.imem_resp_data, addr: aq_head};

    if_fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.redirect_en),
        .push      (resp_keep && !bus.redirect_en),
        .push_data (push_entry),
        .pop       (!buf_empty && !bus.pause),
        .head      (head_bits),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign head_entry     = fetch_entry_t'(head_bits);
    assign bus.inst_valid = !buf_empty;
    assign bus.inst       = buf_empty ? NOP_INST : head_entry.inst;
    assign bus.inst_addr  = buf_empty ? '0 : head_entry.addr;

    // a kept answer always has its request address queued; stale ones have none
    assert property (@(posedge clk) disable iff (rst) !(resp_keep && aq_empty));
    assert property (@(posedge clk) disable iff (rst) aq_count <= outst_q);

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed bench for if_fetch with queue-based reference model and memory
module tb_if_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst;

    if_fetch_if bus0();
    if_fetch_if bus1();

    if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } infl_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    infl_t infl[$];
    ent_t  buff[$];
    mreq_t memq[$];
    logic [31:0] m_pc;
    logic [31:0] seq_next;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int lat      = 1;

    logic s_rst, s_redir, s_ready, s_pause, s_ready2;
    logic [31:0] s_raddr;
    logic o_req_valid, o_inst_valid, o2_req_valid, last_hs;
    logic [31:0] o_req_addr, o_inst, o_inst_addr, o2_req_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic cycle();
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic        pop;
        infl_t       f;
        @(negedge clk);
        rst                 = s_rst;
        bus0.redirect_en    = s_redir;
        bus0.redirect_addr  = s_raddr;
        bus0.imem_req_ready = s_ready;
        bus0.pause          = s_pause;
        bus1.imem_req_ready = s_ready2;
        rv = !s_rst && memq.size() > 0 && memq[0].due <= cyc;
        rd = rv ? mem_data(memq[0].addr) : 32'h0;
        bus0.imem_resp_valid = rv;
        bus0.imem_resp_data  = rd;
        #1;
        o_req_valid  = bus0.imem_req_valid;
        o_req_addr   = bus0.imem_req_addr;
        o_inst_valid = bus0.inst_valid;
        o_inst       = bus0.inst;
        o_inst_addr  = bus0.inst_addr;
        o2_req_valid = bus1.imem_req_valid;
        o2_req_addr  = bus1.imem_req_addr;
        e_req = !s_rst && !s_redir && (infl.size() + buff.size() < DEPTH);
        chk("req_valid", {31'b0, o_req_valid}, {31'b0, e_req});
        if (!s_rst) begin
            chk("req_addr", o_req_addr, m_pc);
            chk("inst_valid", {31'b0, o_inst_valid}, {31'b0, buff.size() > 0});
            chk("inst", o_inst, buff.size() > 0 ? buff[0].data : NOP);
            chk("inst_addr", o_inst_addr, buff.size() > 0 ? buff[0].addr : 32'h0);
            if (!s_redir && !s_pause && o_inst_valid) begin
                chk("seq_addr", o_inst_addr, seq_next);
                seq_next = seq_next + 32'd4;
            end
        end
        last_hs = e_req && s_ready;
        @(posedge clk);
        if (s_rst) begin
            m_pc     = 32'h0;
            seq_next = 32'h0;
            infl.delete();
            buff.delete();
            memq.delete();
        end else begin
            pop = buff.size() > 0 && !s_pause;
            if (pop) void'(buff.pop_front());
            if (rv) begin
                void'(memq.pop_front());
                if (infl.size() > 0) begin
                    f = infl.pop_front();
                    if (!f.stale && !s_redir) buff.push_back('{f.addr, rd});
                end
            end
            if (s_redir) begin
                foreach (infl[i]) infl[i].stale = 1'b1;
                buff.delete();
                m_pc     = {s_raddr[31:2], 2'b00};
                seq_next = m_pc;
            end else if (last_hs) begin
                infl.push_back('{m_pc, 1'b0});
                memq.push_back('{m_pc, cyc + lat});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        s_redir = 1'b1;
        s_raddr = a;
        cycle();
        s_redir = 1'b0;
    endtask

    task automatic wait_two_hs();
        int n = 0;
        for (int i = 0; i < 12 && n < 2; i++) begin
            cycle();
            if (last_hs) n++;
        end
        chk("two_outstanding", n, 2);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_addr);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (o_inst_valid) found = 1;
        end
        chk({name, "_found"}, {31'b0, found}, 32'd1);
        chk({name, "_addr"}, o_inst_addr, exp_addr);
        chk({name, "_data"}, o_inst, ~exp_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold_addr, hold_inst;
        bit          got;
        bus1.imem_resp_valid = 1'b0;
        bus1.imem_resp_data  = 32'h0;
        bus1.redirect_en     = 1'b0;
        bus1.redirect_addr   = 32'h0;
        bus1.pause           = 1'b0;
        m_pc = 32'h0; seq_next = 32'h0;
        s_rst = 1'b1; s_redir = 1'b0; s_raddr = 32'h0;
        s_ready = 1'b1; s_pause = 1'b0; s_ready2 = 1'b0;

        // reset, then free-run with 1-cycle memory
        cycle(); cycle();
        chk("rst_req_valid", {31'b0, o_req_valid}, 32'd0);
        s_rst = 1'b0; s_ready2 = 1'b1;
        cycle();
        chk("c0_inst_valid", {31'b0, o_inst_valid}, 32'd0);
        chk("c0_inst_nop", o_inst, 32'h0000_0013);
        chk("c0_inst_addr", o_inst_addr, 32'h0);
        chk("c0_req_addr", o_req_addr, 32'h0);
        chk("wrap_addr0", o2_req_addr, 32'hFFFF_FFFC);
        chk("wrap_valid0", {31'b0, o2_req_valid}, 32'd1);
        cycle();
        chk("c1_req_addr", o_req_addr, 32'h4);
        chk("c1_inst_valid", {31'b0, o_inst_valid}, 32'd0);
        chk("wrap_addr1", o2_req_addr, 32'h0000_0000);
        s_ready2 = 1'b0;
        cycle();
        chk("c2_inst_valid", {31'b0, o_inst_valid}, 32'd1);
        chk("c2_inst_addr", o_inst_addr, 32'h0);
        chk("c2_inst", o_inst, 32'hFFFF_FFFF);
        chk("c2_req_valid", {31'b0, o_req_valid}, 32'd0);
        chk("wrap_addr2", o2_req_addr, 32'h0000_0004);
        cycle();
        chk("c3_inst_addr", o_inst_addr, 32'h4);
        chk("c3_req_addr", o_req_addr, 32'h8);
        repeat (20) cycle();

        // pause: output frozen, credit exhausted, nothing lost on release
        s_pause = 1'b1;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            cycle();
            if (o_inst_valid) got = 1;
        end
        chk("pause_valid", {31'b0, got}, 32'd1);
        hold_addr = o_inst_addr;
        hold_inst = o_inst;
        repeat (4) begin
            cycle();
            chk("pause_hold_addr", o_inst_addr, hold_addr);
            chk("pause_hold_inst", o_inst, hold_inst);
        end
        chk("pause_no_credit", {31'b0, o_req_valid}, 32'd0);
        s_pause = 1'b0;
        repeat (10) cycle();

        // 3-cycle memory, redirect with two requests in flight
        lat = 3;
        redirect_to(32'h40);
        wait_two_hs();
        redirect_to(32'h100);
        wait_valid("redir100", 32'h100);
        repeat (6) cycle();

        // unaligned redirect target
        redirect_to(32'h203);
        cycle();
        chk("align_req_addr", o_req_addr, 32'h200);
        wait_valid("redir200", 32'h200);

        // memory not ready: request held steady, PC moves only on handshake
        lat = 1;
        s_ready = 1'b0;
        redirect_to(32'h300);
        repeat (4) cycle();
        repeat (4) begin
            cycle();
            chk("stall_valid", {31'b0, o_req_valid}, 32'd1);
            chk("stall_addr", o_req_addr, 32'h300);
        end
        s_ready = 1'b1;
        cycle();
        chk("stall_hs_addr", o_req_addr, 32'h300);
        cycle();
        chk("stall_next_addr", o_req_addr, 32'h304);
        repeat (8) cycle();

        // reset with two requests outstanding
        lat = 3;
        redirect_to(32'h500);
        wait_two_hs();
        s_rst = 1'b1;
        cycle();
        s_rst = 1'b0;
        cycle();
        chk("mrst_inst_valid", {31'b0, o_inst_valid}, 32'd0);
        chk("mrst_inst", o_inst, 32'h0000_0013);
        chk("mrst_inst_addr", o_inst_addr, 32'h0);
        chk("mrst_req_addr", o_req_addr, 32'h0);
        repeat (3) begin
            cycle();
            chk("mrst_still_invalid", {31'b0, o_inst_valid}, 32'd0);
        end
        cycle();
        chk("mrst_first_valid", {31'b0, o_inst_valid}, 32'd1);
        chk("mrst_first_addr", o_inst_addr, 32'h0);
        repeat (10) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
